// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the parameterised UART receiver.
//
// Contents:
//   uart_state_t      receiver state encoding (also exported on o_State)
//   PARITY_MODE_EVEN  PARITY_ODD parameter value selecting even parity
//   PARITY_MODE_ODD   PARITY_ODD parameter value selecting odd parity
//
// Build option: UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } uart_state_t;

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

endpackage

// File: rtl/uart_rx_buf.sv
// uart_rx_buf -- first-word fall-through receive FIFO.
//
// Ports:
//   i_Clock    rising-edge clock
//   i_Reset    synchronous active-high reset (empties the buffer)
//   i_Wr_En    push i_Wr_Data (accepted when not full, or full with a pop)
//   i_Wr_Data  word to push
//   i_Rd_En    pop the head (ignored while empty)
//   o_Rd_Data  current head, valid whenever o_Empty is 0
//   o_Empty    no entries
//   o_Full     DEPTH entries
//   o_Count    occupancy, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_rx_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_Wr_En,
    input  logic [WIDTH-1:0]             i_Wr_Data,
    input  logic                         i_Rd_En,
    output logic [WIDTH-1:0]             o_Rd_Data,
    output logic                         o_Empty,
    output logic                         o_Full,
    output logic [$clog2(DEPTH+1)-1:0]   o_Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_rd;
    logic             do_wr;

    assign o_Empty   = (count == '0);
    assign o_Full    = (count == CNT_W'(DEPTH));
    assign o_Count   = count;
    assign o_Rd_Data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full buffer can still
    // accept a push while it is being read.
    assign do_rd = i_Rd_En && !o_Empty;
    assign do_wr = i_Wr_En && (!o_Full || do_rd);

    always_ff @(posedge i_Clock) begin
        if (do_wr && !i_Reset) begin
            mem[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parameterised UART receiver with receive FIFO and
// sticky error flags.
//
// Ports:
//   i_Clock       rising-edge clock
//   i_Reset       synchronous active-high reset, highest priority
//   i_Rx_Serial   asynchronous serial input, idle high
//   i_Read_Flag   pop the FIFO head (ignored while empty)
//   i_Clear_Err   clear the sticky error flags
//   o_Rx_Byte     FIFO head (first-word fall-through)
//   o_Rx_DV       high in the cycle a received frame is pushed
//   o_Empty       FIFO empty
//   o_Full        FIFO full
//   o_Count       FIFO occupancy
//   o_Frame_Err   sticky: stop bit sampled low
//   o_Parity_Err  sticky: parity bit mismatch (0 unless parity built in)
//   o_Overrun     sticky: frame dropped because the FIFO was full
//   o_State       current receiver state, for observation
//
// Build option: define UART_RX_PARITY_EN to receive one parity bit after
// the data bits; PARITY_ODD selects even (0) or odd (1) parity.
//
// Handshake: o_Rx_DV is a single-cycle strobe with no back-pressure; the
// consumer drains the FIFO with i_Read_Flag, one entry per high cycle
// while o_Empty is 0.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset,
    input  logic                              i_Rx_Serial,
    input  logic                              i_Read_Flag,
    input  logic                              i_Clear_Err,
    output logic [DATA_BITS-1:0]              o_Rx_Byte,
    output logic                              o_Rx_DV,
    output logic                              o_Empty,
    output logic                              o_Full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Count,
    output logic                              o_Frame_Err,
    output logic                              o_Parity_Err,
    output logic                              o_Overrun,
    output uart_state_t                       o_State
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT-1)/2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT-1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS-1);

    // Two-flop synchroniser; both flops idle high so reset never looks
    // like a start bit.
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 set_frame_err;
    logic                 cleanup;
    logic                 buf_full;
    logic                 push;
    logic                 set_overrun;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD == PARITY_MODE_ODD);
    logic set_parity_err;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        data_d        = data_q;
        set_frame_err = 1'b0;
        cleanup       = 1'b0;
`ifdef UART_RX_PARITY_EN
        set_parity_err = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) begin
                    state_d = S_START;
                end
            end

            // Re-check the start bit at its midpoint; a high line here
            // was a glitch and is dropped silently.
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // From the start midpoint, one full bit period lands in the
            // middle of each following bit.
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_sync;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            // XOR of the data gives the even-parity bit; invert for odd.
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync != ((^data_q) ^ PAR_ODD)) begin
                        set_parity_err = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        state_d = S_CLEANUP;
                    end else begin
                        set_frame_err = 1'b1;
                        state_d       = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CLEANUP: begin
                cleanup = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A full FIFO still takes the frame when the consumer pops in the
    // same cycle; otherwise the frame is lost and flagged.
    assign push        = cleanup && (!buf_full || i_Read_Flag) && !i_Reset;
    assign set_overrun = cleanup && buf_full && !i_Read_Flag;
    assign o_Rx_DV     = push;
    assign o_Full      = buf_full;
    assign o_State     = state_q;

    uart_rx_buf #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Wr_En   (push),
        .i_Wr_Data (data_q),
        .i_Rd_En   (i_Read_Flag),
        .o_Rd_Data (o_Rx_Byte),
        .o_Empty   (o_Empty),
        .o_Full    (buf_full),
        .o_Count   (o_Count)
    );

    // Sticky flags: a new error event outranks a clear in the same cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            o_Frame_Err <= set_frame_err | (o_Frame_Err & ~i_Clear_Err);
            o_Overrun   <= set_overrun   | (o_Overrun   & ~i_Clear_Err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Parity_Err <= 1'b0;
        end else begin
            o_Parity_Err <= set_parity_err | (o_Parity_Err & ~i_Clear_Err);
        end
    end
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clocks per serial bit (integer >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer entries (power of two, >= 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN).
REQ-005 SHALL have port i_Clock, input, width 1: single clock; all logic rising-edge.
REQ-006 SHALL have port i_Reset, input, width 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_Rx_Serial, input, width 1: asynchronous serial line, idle high.
REQ-008 SHALL have port i_Read_Flag, input, width 1: pop FIFO head.
REQ-009 SHALL have port i_Clear_Err, input, width 1: clear sticky error flags.
REQ-010 SHALL have port o_Rx_Byte, output, width DATA_BITS: FIFO head (first-word fall-through).
REQ-011 SHALL have port o_Rx_DV, output, width 1: one-cycle pulse per successful FIFO push.
REQ-012 SHALL have ports o_Empty and o_Full, outputs, width 1 each: FIFO status.
REQ-013 SHALL have port o_Count, output, width $clog2(FIFO_DEPTH+1): FIFO occupancy.
REQ-014 SHALL have ports o_Frame_Err, o_Parity_Err and o_Overrun, outputs, width 1 each: sticky error flags.

Function
REQ-015 SHALL pass i_Rx_Serial through a two-flop synchroniser (both flops reset to 1); all sampling uses the second flop.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP.
REQ-017 IDLE -> START when the synchronised line is 0; clock counter and bit index are zeroed in IDLE.
REQ-018 START SHALL resample at count (CLKS_PER_BIT-1)/2: line 0 -> DATA with counter zeroed; line 1 -> IDLE (glitch rejected, nothing recorded).
REQ-019 DATA SHALL sample every CLKS_PER_BIT clocks, LSB first, into bit index 0..DATA_BITS-1; after the last bit -> PARITY if compiled in, else -> STOP.
REQ-020 STOP SHALL sample CLKS_PER_BIT clocks after the previous sample: 1 -> CLEANUP; 0 -> set o_Frame_Err, discard frame, -> IDLE.
REQ-021 CLEANUP SHALL last one cycle: push the frame if the FIFO is not full, or if it is full and i_Read_Flag pops in the same cycle; otherwise set o_Overrun and drop the frame. Then -> IDLE.
REQ-022 o_Rx_DV SHALL pulse in the push cycle only.
REQ-023 FIFO: o_Rx_Byte SHALL show the head whenever o_Empty=0; i_Read_Flag with o_Empty=1 SHALL be ignored; a simultaneous push and pop SHALL leave o_Count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Error flags SHALL stay set until i_Clear_Err; a set event in the same cycle as i_Clear_Err SHALL win.
REQ-026 Clock counter width SHALL be $clog2(CLKS_PER_BIT); counter arithmetic SHALL never overflow.

Reset
REQ-027 i_Reset SHALL return the state machine to IDLE, empty the FIFO (o_Empty=1, o_Full=0, o_Count=0), zero o_Rx_DV and all error flags, and set the synchroniser flops to 1.
REQ-028 Reset in mid-frame SHALL discard the partial frame with no push and no error flag.
REQ-029 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, PARITY SHALL sample one extra bit. A mismatch against the parity selected by PARITY_ODD SHALL set o_Parity_Err, discard the frame and go to IDLE; a match SHALL go to STOP.
REQ-031 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent, and o_Parity_Err SHALL be tied to 0.

Structure
REQ-032 Shared package uart_pkg SHALL hold the state-encoding typedef and parity-mode localparams.
REQ-033 The FIFO SHALL be the sub-module uart_rx_buf, parametrised by width and depth.

Verification
REQ-034 CLKS_PER_BIT=16, DATA_BITS=8: frame 0xA5 -> o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Count=1.
REQ-035 Low pulse of 4 clocks on the idle line -> no push and no error flags.
REQ-036 Stop bit driven 0 -> o_Frame_Err=1, o_Count unchanged; i_Clear_Err -> flag cleared.
REQ-037 FIFO_DEPTH=4: send 5 frames with no reads -> o_Full=1, o_Overrun=1, head is frame 1; pop 4 -> frames 1-4 in order, then o_Empty=1.
REQ-038 UART_RX_PARITY_EN with PARITY_ODD=0: 0x03 with parity bit 1 -> o_Parity_Err=1, no push; with parity bit 0 -> push.
REQ-039 Assert i_Reset during DATA bit 3 -> state IDLE, o_Count=0, no o_Rx_DV pulse; a following clean frame 0x5A is received correctly.
